// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply is a fixed-latency product; divide is restoring radix-2, one quotient bit per cycle.
module mdu_hilo #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned CntMax = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int unsigned CntW   = $clog2(CntMax);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               sgn_q, sgn_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    logic               idle, accept, div_signed, ge;
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic [WIDTH:0]     trial, diff;

    assign idle   = (state_q == StIdle);
    assign accept = start_i & ~flush_i & idle;

    // Sign-extending both operands to 2*WIDTH makes the truncated product correct for MULT.
    assign mul_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign mul_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign prod  = mul_a * mul_b;

    // a_q doubles as the dividend shift register and collects quotient bits from the LSB.
    assign trial = {rem_q, a_q[WIDTH-1]};
    assign diff  = trial - {1'b0, b_q};
    assign ge    = (trial >= {1'b0, b_q});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sgn_d      = sgn_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_signed = (op_i == OpDiv);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op_i)
                        OpMult, OpMultu: begin
                            a_d     = srca_i;
                            b_d     = srcb_i;
                            sgn_d   = (op_i == OpMult);
                            cnt_d   = CntW'(MUL_LATENCY - 1);
                            state_d = StMul;
                        end
                        OpDiv, OpDivu: begin
                            a_d     = (div_signed & srca_i[WIDTH-1]) ? -srca_i : srca_i;
                            b_d     = (div_signed & srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;
                            qneg_d  = div_signed & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
                            rneg_d  = div_signed & srca_i[WIDTH-1];
                            dz_d    = (srcb_i == '0);
                            rem_d   = '0;
                            cnt_d   = CntW'(WIDTH - 1);
                            state_d = StDiv;
                        end
                        OpMthi:  hi_d = srca_i;
                        OpMtlo:  lo_d = srca_i;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDiv: begin
                rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // With a zero divisor the remainder is |a|; the sign fix restores the raw dividend.
                lo_d    = dz_q ? '1 : (qneg_q ? -a_q : a_q);
                hi_d    = rneg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = ~idle | (accept & ~op_i[2]);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS five-stage pipeline. It sits beside the execute-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute. It raises a stall request to the hazard unit while an operation is in flight, and it supplies HI/LO to the MFHI/MFLO datapath mux. It generalises the single-cycle ALU path to configurable width and multiply latency, and adds iterative division.

## Interface
- WIDTH, 32: operand and HI/LO width; even, ≥ 4.
- MUL_LATENCY, 2: cycles spent in MUL state; ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset is synchronous and active-high.
- start_i  in  1  operation request from execute stage, qualified by op_i.
- op_i  in  3  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - Codes 6–7 are no-ops.
- srca_i  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- srcb_i  in  WIDTH  rt operand (divisor / multiplier).
- flush_i  in  1  cancels any in-flight operation (exception / pipeline flush).
- busy_o  out  1  stall request to hazard unit.
- done_o  out  1  one-cycle pulse: HI/LO just updated by MUL/DIV.
- hi_o  out  WIDTH  current HI.
- lo_o  out  WIDTH  current LO.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start_i + MULT/MULTU:
  - Register operands, state→MUL, cycle counter = MUL_LATENCY−1.
- MUL:
  - Counter decrements each cycle.
  - At counter 0, write the 2·WIDTH product: HI = upper half, LO = lower half. Set done, state→IDLE.
  - MULT is signed; MULTU is unsigned.
- IDLE + start_i + DIV/DIVU:
  - Register |a|, |b| (raw values for DIVU) and the sign flags.
  - Clear the partial remainder; state→DIV; counter = WIDTH−1.
- DIV: restoring radix-2 division, one quotient bit per cycle, MSB first. After the bit at counter 0, state→FIX.
- FIX:
  - Quotient is negated when the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (DIV only).
  - Write LO = quotient, HI = remainder; set done, state→IDLE.
- Divide by zero (srcb_i = 0): full latency still applies. Result is LO = all ones, HI = dividend (raw srca_i).
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0. This falls out of the algorithm and needs no special case.
- MTHI/MTLO in IDLE: HI (or LO) ← srca_i at the same edge. No busy, no done.
- start_i while state ≠ IDLE is ignored; the hazard unit holds the instruction in execute. Same for ops 6–7 in any state.
- flush_i:
  - Any state → IDLE at the next edge; HI/LO unchanged; no done.
  - flush_i with start_i in the same cycle: flush wins, start ignored (including MTHI/MTLO).
  - flush_i in the final MUL cycle or in FIX: no write.

## Timing
- Reset (rst high at an edge): state IDLE, hi_o = 0, lo_o = 0, done_o = 0, busy_o = 0.
- rst mid-operation aborts it, exactly like flush, but also clears HI/LO.
- busy_o is combinational: (state ≠ IDLE) | (start_i & ~flush_i & state = IDLE & op_i ∈ {0..3}). It is high in the start cycle itself.
- Define cycle 0 as the cycle start_i is sampled.
- MUL: busy_o high in cycles 0..MUL_LATENCY. HI/LO and done_o = 1 are valid in cycle MUL_LATENCY+1.
- DIV: busy_o high in cycles 0..WIDTH+1. HI/LO and done_o = 1 are valid in cycle WIDTH+2.
- A new start is accepted in the done_o cycle (back-to-back).
- MTHI/MTLO: hi_o/lo_o change in cycle 1.
- done_o is registered and lasts exactly one cycle.
- hi_o/lo_o are registered outputs and never glitch.

## Test plan
- Reset, then signed multiply:
  - Stimulus: rst for 2 cycles, then MULT with a = 0xFFFFFFFE (−2), b = 3.
  - Required: busy high cycles 0–2; in cycle 3, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, done = 1 for one cycle.
- Unsigned multiply, WIDTH = 32:
  - Stimulus: MULTU with a = b = 0xFFFFFFFF.
  - Required: HI = 0xFFFFFFFE, LO = 0x00000001.
- Signed divide:
  - Stimulus: DIV with a = −7 (0xFFFFFFF9), b = 2.
  - Required: done in cycle 34; LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1).
  - Stimulus: DIVU with a = 100, b = 7.
  - Required: LO = 14, HI = 2.
- Divide corner cases:
  - Stimulus: DIV with a = 0x80000000, b = 0xFFFFFFFF.
  - Required: LO = 0x80000000, HI = 0.
  - Stimulus: DIVU with a = 5, b = 0.
  - Required: LO = 0xFFFFFFFF, HI = 5; latency unchanged.
- Flush and ignored start:
  - Stimulus: MTLO with 0x1234 (LO = 0x1234 in cycle 1); then DIV; flush_i in cycle 10.
  - Required: busy low from cycle 11, LO remains 0x1234, no done pulse.
  - Stimulus: a second start mid-DIV.
  - Required: ignored.
- Back-to-back and parameter sweep:
  - Stimulus: MULT issued in the done cycle of a DIV.
  - Required: correct results for both operations.
  - Stimulus: repeat the scenarios with WIDTH = 8, MUL_LATENCY = 1 against a reference model over 10k random operands.
  - Required: all results match.
